// File: rtl/port_arb_pkg.sv
// Shared types and constants for the three-port round-robin arbiter.
// Source codes, default widths and the output-stage state type.
package port_arb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_P1   = 2'd1;
  localparam logic [1:0] SRC_P2   = 2'd2;
  localparam logic [1:0] SRC_P3   = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/port_arb_if.sv
// Handshake bundle between three requesters, the arbiter and downstream.
// slave: arbiter view; master: requester/downstream view (PORT_ARB_STATS_EN adds counters).
interface port_arb_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);

  logic [DATA_W-1:0] port1_data;
  logic [DATA_W-1:0] port2_data;
  logic [DATA_W-1:0] port3_data;
  logic              port1_valid;
  logic              port2_valid;
  logic              port3_valid;
  logic              port1_ready;
  logic              port2_ready;
  logic              port3_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [1:0]        out_src;
  logic              out_ready;
`ifdef PORT_ARB_STATS_EN
  logic              stats_clr;
  logic [CNT_W-1:0]  port1_cnt;
  logic [CNT_W-1:0]  port2_cnt;
  logic [CNT_W-1:0]  port3_cnt;
`endif

  modport slave (
    input  port1_data, port2_data, port3_data,
    input  port1_valid, port2_valid, port3_valid,
    output port1_ready, port2_ready, port3_ready,
    output out_data, out_valid, out_src,
    input  out_ready
`ifdef PORT_ARB_STATS_EN
    , input stats_clr
    , output port1_cnt, port2_cnt, port3_cnt
`endif
  );

  modport master (
    output port1_data, port2_data, port3_data,
    output port1_valid, port2_valid, port3_valid,
    input  port1_ready, port2_ready, port3_ready,
    input  out_data, out_valid, out_src,
    output out_ready
`ifdef PORT_ARB_STATS_EN
    , output stats_clr
    , input port1_cnt, port2_cnt, port3_cnt
`endif
  );

endinterface

// File: rtl/port_arb_rr.sv
// Combinational round-robin picker: search starts after i_last, 1->2->3->1.
// Ports: i_valid[2:0] (bit0=port1), i_last; o_grant (0 if none), o_any.
module port_arb_rr
  import port_arb_pkg::*;
(
  input  logic [2:0] i_valid,
  input  logic [1:0] i_last,
  output logic [1:0] o_grant,
  output logic       o_any
);

  assign o_any = |i_valid;

  always_comb begin
    o_grant = SRC_NONE;
    unique case (i_last)
      SRC_P1: begin
        if (i_valid[1])      o_grant = SRC_P2;
        else if (i_valid[2]) o_grant = SRC_P3;
        else if (i_valid[0]) o_grant = SRC_P1;
      end
      SRC_P2: begin
        if (i_valid[2])      o_grant = SRC_P3;
        else if (i_valid[0]) o_grant = SRC_P1;
        else if (i_valid[1]) o_grant = SRC_P2;
      end
      // SRC_P3 and the unreachable SRC_NONE both start at port1
      default: begin
        if (i_valid[0])      o_grant = SRC_P1;
        else if (i_valid[1]) o_grant = SRC_P2;
        else if (i_valid[2]) o_grant = SRC_P3;
      end
    endcase
  end

endmodule

// File: rtl/port_arbiter.sv
// Round-robin arbiter: three valid/ready ports into one registered output.
// Ports: clk, rst_n, bus (port_arb_if.slave). PORT_ARB_STATS_EN adds counters.
module port_arbiter
  import port_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic     clk,
  input  logic     rst_n,
  port_arb_if.slave bus
);

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_src;
  logic [1:0]        r_last;

  logic [2:0]        w_valid;
  logic [1:0]        w_grant;
  logic              w_any;
  logic              w_load;
  logic              w_acc;
  logic [DATA_W-1:0] w_mux;

  assign w_valid = {bus.port3_valid,
                    bus.port2_valid,
                    bus.port1_valid};

  port_arb_rr u_rr (
    .i_valid (w_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  // Output register may take a new beat when empty or being drained.
  assign w_load = (r_state == EMPTY) || bus.out_ready;
  assign w_acc  = w_load && w_any;

  assign bus.port1_ready = w_load && (w_grant == SRC_P1);
  assign bus.port2_ready = w_load && (w_grant == SRC_P2);
  assign bus.port3_ready = w_load && (w_grant == SRC_P3);

  always_comb begin
    w_mux = '0;
    unique case (w_grant)
      SRC_P1:  w_mux = bus.port1_data;
      SRC_P2:  w_mux = bus.port2_data;
      SRC_P3:  w_mux = bus.port3_data;
      default: w_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_src   <= SRC_NONE;
      r_last  <= SRC_P3;
    end else if (w_acc) begin
      r_state <= FULL;
      r_data  <= w_mux;
      r_src   <= w_grant;
      r_last  <= w_grant;
    end else if (w_load) begin
      // Drained with nothing to refill: data keeps its last value.
      r_state <= EMPTY;
      r_src   <= SRC_NONE;
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_valid = (r_state == FULL);
  assign bus.out_src   = r_src;

`ifdef PORT_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt1;
  logic [CNT_W-1:0] r_cnt2;
  logic [CNT_W-1:0] r_cnt3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt1 <= '0;
      r_cnt2 <= '0;
      r_cnt3 <= '0;
    end else if (bus.stats_clr) begin
      r_cnt1 <= '0;
      r_cnt2 <= '0;
      r_cnt3 <= '0;
    end else if (w_acc) begin
      unique case (w_grant)
        SRC_P1:  r_cnt1 <= r_cnt1 + 1'b1;
        SRC_P2:  r_cnt2 <= r_cnt2 + 1'b1;
        SRC_P3:  r_cnt3 <= r_cnt3 + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.port1_cnt = r_cnt1;
  assign bus.port2_cnt = r_cnt2;
  assign bus.port3_cnt = r_cnt3;
`endif

endmodule

// File: tb/tb_port_arbiter.sv
// Self-checking bench for port_arbiter: reference model plus beat scoreboard.
// Stats section is active only when PORT_ARB_STATS_EN is defined.
module tb_port_arbiter;
  import port_arb_pkg::*;

`ifdef PORT_ARB_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = DEF_CNT_W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  port_arb_if #(.DATA_W(8), .CNT_W(CNT_W)) bus ();

  port_arbiter #(.DATA_W(8), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic       m_ov;
  logic [7:0] m_data;
  logic [1:0] m_src;
  logic [1:0] m_last;
  int         m_cnt [3];
  logic [9:0] sbq [$];

  function automatic int pick(logic [2:0] v, int last);
    for (int k = 1; k <= 3; k++) begin
      int p;
      p = ((last + k - 1) % 3) + 1;
      if (v[p-1]) return p;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_ov = 1'b0; m_data = 8'h00; m_src = 2'd0; m_last = 2'd3;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    sbq.delete();
  endtask

  task automatic drive(logic [2:0] v, logic [7:0] d1, logic [7:0] d2,
                       logic [7:0] d3, logic ordy);
    bus.port1_valid = v[0]; bus.port2_valid = v[1]; bus.port3_valid = v[2];
    bus.port1_data = d1; bus.port2_data = d2; bus.port3_data = d3;
    bus.out_ready = ordy;
  endtask

  // One clock cycle: called just after a falling edge with inputs set.
  task automatic cyc();
    logic [2:0] v;
    logic [7:0] d;
    logic [9:0] e;
    bit ld;
    bit clr;
    int g;
    #1;
    v = {bus.port3_valid, bus.port2_valid, bus.port1_valid};
    ld = !m_ov || bus.out_ready;
    g = ld ? pick(v, int'(m_last)) : 0;
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_src", bus.out_src, m_src);
    if (m_ov) chk("out_data", bus.out_data, m_data);
    chk("rdy1", bus.port1_ready, g == 1);
    chk("rdy2", bus.port2_ready, g == 2);
    chk("rdy3", bus.port3_ready, g == 3);
`ifdef PORT_ARB_STATS_EN
    chk("cnt1", bus.port1_cnt, m_cnt[0]);
    chk("cnt2", bus.port2_cnt, m_cnt[1]);
    chk("cnt3", bus.port3_cnt, m_cnt[2]);
    clr = bus.stats_clr;
`else
    clr = 1'b0;
`endif
    if (bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
      else begin
        e = sbq.pop_front();
        chk("sb_beat", {bus.out_src, bus.out_data}, e);
      end
    end
    d = (g == 1) ? bus.port1_data : (g == 2) ? bus.port2_data : bus.port3_data;
    @(posedge clk);
    if (g != 0) begin
      m_ov = 1'b1; m_data = d; m_src = 2'(g); m_last = 2'(g);
      sbq.push_back({2'(g), d});
    end else if (ld) begin
      m_ov = 1'b0; m_src = 2'd0;
    end
    if (clr) for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    else if (g != 0) m_cnt[g-1] = (m_cnt[g-1] + 1) % (1 << CNT_W);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_src", bus.out_src, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
`ifdef PORT_ARB_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    do_reset();

    // Single beat from port2
    drive(3'b010, 8'h00, 8'h5A, 8'h00, 1'b1);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    #1;
    chk("single_data", bus.out_data, 8'h5A);
    chk("single_src", bus.out_src, 2);
    cyc();
    cyc();

    // Three-way contention from a fresh reset
    do_reset();
    drive(3'b111, 8'h11, 8'h22, 8'h33, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rr_seq", bus.out_src, (i % 3) + 1);
    end

    // Back-pressure: 0x44 from port1 held while port3 waits
    drive(3'b001, 8'h44, 8'h00, 8'h00, 1'b1);
    cyc();
    drive(3'b100, 8'h00, 8'h00, 8'h77, 1'b1);
    cyc();
    drive(3'b001, 8'h44, 8'h00, 8'h00, 1'b1);
    cyc();
    drive(3'b100, 8'h00, 8'h00, 8'h77, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_hold", bus.out_data, 8'h44);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy3", bus.port3_ready, 1);
    cyc();

    // Drain to empty
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc();
    cyc();
    chk("drain_valid", bus.out_valid, 0);
    chk("drain_src", bus.out_src, 0);

    // Reset in the middle of traffic
    drive(3'b111, 8'hA1, 8'hA2, 8'hA3, 1'b1);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_src", bus.out_src, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_src", bus.out_src, 1);
    chk("post_rst_data", bus.out_data, 8'hA1);
    cyc();

`ifdef PORT_ARB_STATS_EN
    do_reset();
    drive(3'b001, 8'h01, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cyc();
    drive(3'b100, 8'h00, 8'h00, 8'h03, 1'b1);
    for (int i = 0; i < 2; i++) cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc();
    chk("stat_p1", bus.port1_cnt, 5);
    chk("stat_p3", bus.port3_cnt, 2);
    // Clear wins over a simultaneous increment
    drive(3'b001, 8'h09, 8'h00, 8'h00, 1'b1);
    bus.stats_clr = 1'b1;
    cyc();
    bus.stats_clr = 1'b0;
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    #1;
    chk("stat_clr1", bus.port1_cnt, 0);
    chk("stat_clr3", bus.port3_cnt, 0);
    cyc();
    drive(3'b010, 8'h00, 8'h22, 8'h00, 1'b1);
    for (int i = 0; i < 17; i++) cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    #1;
    chk("stat_wrap", bus.port2_cnt, 1);
    cyc();
`endif

    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc();
    cyc();
    chk("sb_leftover", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
